log_unit_param: RTL
===================

LOG_UNIT_PARAM -- requirements
Module: log_unit_param

Interface
REQ-001 Parameter RS_ID_WIDTH, default 5: reservation-station tag width.
REQ-002 Parameter DATA_WIDTH, default 32: operand/result width; legal values 32 and 64.
REQ-003 Parameter STAGES, default 3: pipeline depth; legal range 2..5.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous pipeline kill.
REQ-007 input_valid  in  1, input_ready  out  1: input handshake.
REQ-008 rs_id_in  in  RS_ID_WIDTH, result_reg_addr_in  in  5: tags carried with the operation.
REQ-009 op1, op2  in  DATA_WIDTH each: operands, bit 0 = MSB.
REQ-010 so  in  1: XER summary overflow, passed to CR0.
REQ-011 control  in  log_decode_t: operation select plus alter_CR0.
REQ-012 output_valid  out  1, output_ready  in  1: output handshake.
REQ-013 rs_id_out  out  RS_ID_WIDTH, result_reg_addr_out  out  5: tags returned with the result.
REQ-014 result  out  DATA_WIDTH, cr0_xer  out  cond_exception_t: result and condition outputs.

Function
REQ-015 Operations: AND, OR, XOR, NAND, NOR, EQUIVALENT, AND_COMPLEMENT, OR_COMPLEMENT, EXTEND_SIGN_BYTE, EXTEND_SIGN_HALFWORD, EXTEND_SIGN_WORD, COUNT_LEADING_ZEROS; any other encoding SHALL yield result 0.
REQ-016 EXTEND_SIGN_WORD SHALL act as pass-through of op1 when DATA_WIDTH=32.
REQ-017 COUNT_LEADING_ZEROS SHALL count zeros from bit 0; an all-zero op1 SHALL give DATA_WIDTH.
REQ-018 Each stage SHALL hold a valid bit, the tags, control and data; stage k SHALL load when it is empty or when stage k+1 loads in the same cycle.
REQ-019 The last stage SHALL be able to load when output_ready=1, so a full pipe sustains one result per cycle.
REQ-020 input_ready SHALL equal the stage-0 load enable; an accepted operation SHALL have output_valid exactly STAGES cycles later when there are no stalls.
REQ-021 While output_valid=1 and output_ready=0, all outputs SHALL hold stable and no valid entry SHALL be lost or duplicated.
REQ-022 CR0 computation: lt = result[0], eq = (result==0), gt = !lt & !eq, so = so sampled at input.
REQ-023 cr0_xer.CR0_valid SHALL equal control.alter_CR0; cr0_xer.xer and cr0_xer.xer_valid SHALL be 0.
REQ-024 flush=1 SHALL clear every stage valid bit at the next edge, overriding loads.
REQ-025 An input presented in a flush cycle SHALL be dropped, and input_ready SHALL be 0 in that cycle.
REQ-026 Operations SHALL emerge in acceptance order.

Reset
REQ-027 rst=0 SHALL immediately clear all valid bits, tags, data, result and cr0_xer to 0, independent of clk.
REQ-028 After reset, input_ready SHALL be 1; an in-flight operation SHALL be discarded.

Configuration
REQ-029 Macro LOG_UNIT_POPCNT_EN: when defined, operation POPULATION_COUNT_BYTES SHALL place the count of ones of each byte in that byte; when undefined, that encoding SHALL yield result 0 and CR0 computed on 0.

Verification
REQ-030 Test 1: STAGES=3, op1=0xF0F0F0F0, op2=0x0FF00FF0, AND, alter_CR0=1 -> result 0x00F000F0 after 3 cycles, lt=0, gt=1, eq=0.
REQ-031 Test 2: COUNT_LEADING_ZEROS with op1=0 -> result 32 (64 when DATA_WIDTH=64); op1=0x00010000 -> result 15.
REQ-032 Test 3: EXTEND_SIGN_BYTE, op1=0x00000080, so=1 -> 0xFFFFFF80, lt=1, so=1.
REQ-033 Test 4: back-to-back stream of 10 operations with output_ready toggling every cycle -> 10 results in order, tags intact, none lost.
REQ-034 Test 5: pipe full with output_ready=0, flush pulse -> output_valid=0 next cycle, input_ready=1.
REQ-035 Test 6: rst asserted mid-stream -> outputs 0 before the next clk edge; with LOG_UNIT_POPCNT_EN defined, op1=0x0103FF00 -> 0x01020800.

Source files
------------

// File: rtl/log_unit_param_if.sv
// Shared types and the handshake/bus interface for the log_unit_param logical unit.
// Operand and result vectors use big-endian numbering: bit 0 is the MSB.
package log_unit_pkg;

    typedef enum logic [3:0] {
        OP_AND                    = 4'd0,
        OP_OR                     = 4'd1,
        OP_XOR                    = 4'd2,
        OP_NAND                   = 4'd3,
        OP_NOR                    = 4'd4,
        OP_EQUIVALENT             = 4'd5,
        OP_AND_COMPLEMENT         = 4'd6,
        OP_OR_COMPLEMENT          = 4'd7,
        OP_EXTEND_SIGN_BYTE       = 4'd8,
        OP_EXTEND_SIGN_HALFWORD   = 4'd9,
        OP_EXTEND_SIGN_WORD       = 4'd10,
        OP_COUNT_LEADING_ZEROS    = 4'd11,
        OP_POPULATION_COUNT_BYTES = 4'd12
    } log_op_t;

    typedef struct packed {
        log_op_t op;
        logic    alter_CR0;
    } log_decode_t;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
    } cr0_t;

    typedef struct packed {
        cr0_t       CR0;
        logic       CR0_valid;
        logic [2:0] xer;
        logic       xer_valid;
    } cond_exception_t;

endpackage

interface log_unit_param_if
    import log_unit_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int DATA_WIDTH  = 32
) ();

    logic                   input_valid;
    logic                   input_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_in;
    logic [4:0]             result_reg_addr_in;
    logic [0:DATA_WIDTH-1]  op1;
    logic [0:DATA_WIDTH-1]  op2;
    logic                   so;
    log_decode_t            control;

    logic                   output_valid;
    logic                   output_ready;
    logic [RS_ID_WIDTH-1:0] rs_id_out;
    logic [4:0]             result_reg_addr_out;
    logic [0:DATA_WIDTH-1]  result;
    cond_exception_t        cr0_xer;

    modport master (
        output input_valid, rs_id_in, result_reg_addr_in, op1, op2, so, control, output_ready,
        input  input_ready, output_valid, rs_id_out, result_reg_addr_out, result, cr0_xer
    );

    modport slave (
        input  input_valid, rs_id_in, result_reg_addr_in, op1, op2, so, control, output_ready,
        output input_ready, output_valid, rs_id_out, result_reg_addr_out, result, cr0_xer
    );

endinterface

// File: rtl/log_unit_param.sv
// Pipelined logical unit: bitwise ops, sign extension, count-leading-zeros, CR0 generation.
// Optional feature macro: LOG_UNIT_POPCNT_EN enables POPULATION_COUNT_BYTES.
module log_unit_param
    import log_unit_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int STAGES      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    log_unit_param_if.slave  bus
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic [0:DATA_WIDTH-1] w_ext_b;
    logic [0:DATA_WIDTH-1] w_ext_h;
    logic [0:DATA_WIDTH-1] w_ext_w;
    logic [CW-1:0]         w_clz;
    logic [0:DATA_WIDTH-1] w_res;
    cond_exception_t       w_cr;
    logic [STAGES-1:0]     w_ld;

    logic [STAGES-1:0]      r_vld;
    logic [RS_ID_WIDTH-1:0] r_rs_id [STAGES];
    logic [4:0]             r_addr  [STAGES];
    logic [0:DATA_WIDTH-1]  r_res   [STAGES];
    cond_exception_t        r_cr    [STAGES];

    assign w_ext_b = {{(DATA_WIDTH-8){bus.op1[DATA_WIDTH-8]}},   bus.op1[DATA_WIDTH-8:DATA_WIDTH-1]};
    assign w_ext_h = {{(DATA_WIDTH-16){bus.op1[DATA_WIDTH-16]}}, bus.op1[DATA_WIDTH-16:DATA_WIDTH-1]};

    // A 32-bit datapath has no upper word to fill, so the word extension degenerates to a copy.
    generate
        if (DATA_WIDTH == 32) begin : g_extw_pass
            assign w_ext_w = bus.op1;
        end else begin : g_extw_sign
            assign w_ext_w = {{(DATA_WIDTH-32){bus.op1[DATA_WIDTH-32]}},
                              bus.op1[DATA_WIDTH-32:DATA_WIDTH-1]};
        end
    endgenerate

    always_comb begin : p_clz
        logic w_hit;
        w_hit = 1'b0;
        w_clz = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (!w_hit) begin
                if (bus.op1[i]) w_hit = 1'b1;
                else            w_clz = w_clz + CW'(1);
            end
        end
    end

`ifdef LOG_UNIT_POPCNT_EN
    logic [0:DATA_WIDTH-1] w_pop;

    always_comb begin
        w_pop = '0;
        for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
            for (int unsigned j = 0; j < 8; j++) begin
                w_pop[8*b +: 8] = w_pop[8*b +: 8] + 8'(bus.op1[8*b + j]);
            end
        end
    end
`endif

    always_comb begin
        w_res = '0;
        case (bus.control.op)
            OP_AND:                  w_res = bus.op1 & bus.op2;
            OP_OR:                   w_res = bus.op1 | bus.op2;
            OP_XOR:                  w_res = bus.op1 ^ bus.op2;
            OP_NAND:                 w_res = ~(bus.op1 & bus.op2);
            OP_NOR:                  w_res = ~(bus.op1 | bus.op2);
            OP_EQUIVALENT:           w_res = ~(bus.op1 ^ bus.op2);
            OP_AND_COMPLEMENT:       w_res = bus.op1 & ~bus.op2;
            OP_OR_COMPLEMENT:        w_res = bus.op1 | ~bus.op2;
            OP_EXTEND_SIGN_BYTE:     w_res = w_ext_b;
            OP_EXTEND_SIGN_HALFWORD: w_res = w_ext_h;
            OP_EXTEND_SIGN_WORD:     w_res = w_ext_w;
            OP_COUNT_LEADING_ZEROS:  w_res = DATA_WIDTH'(w_clz);
`ifdef LOG_UNIT_POPCNT_EN
            OP_POPULATION_COUNT_BYTES: w_res = w_pop;
`endif
            default:                 w_res = '0;
        endcase
    end

    always_comb begin
        w_cr           = '0;
        w_cr.CR0.lt    = w_res[0];
        w_cr.CR0.eq    = (w_res == '0);
        w_cr.CR0.gt    = !w_res[0] && (w_res != '0);
        w_cr.CR0.so    = bus.so;
        w_cr.CR0_valid = bus.control.alter_CR0;
    end

    // A stage may load when it or any stage downstream of it is empty, or the sink is taking a result.
    always_comb begin : p_ld
        logic w_room;
        w_room = bus.output_ready;
        w_ld   = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_room                 = w_room || !r_vld[STAGES-1-k];
            w_ld[STAGES-1-k]       = w_room;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_rs_id[k] <= '0;
                r_addr[k]  <= '0;
                r_res[k]   <= '0;
                r_cr[k]    <= '0;
            end
        end else begin
            if (w_ld[0]) begin
                r_vld[0]   <= bus.input_valid;
                r_rs_id[0] <= bus.rs_id_in;
                r_addr[0]  <= bus.result_reg_addr_in;
                r_res[0]   <= w_res;
                r_cr[0]    <= w_cr;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (w_ld[k]) begin
                    r_vld[k]   <= r_vld[k-1];
                    r_rs_id[k] <= r_rs_id[k-1];
                    r_addr[k]  <= r_addr[k-1];
                    r_res[k]   <= r_res[k-1];
                    r_cr[k]    <= r_cr[k-1];
                end
            end
            if (flush) begin
                r_vld <= '0;
            end
        end
    end

    assign bus.input_ready         = w_ld[0] && !flush;
    assign bus.output_valid        = r_vld[STAGES-1];
    assign bus.rs_id_out           = r_rs_id[STAGES-1];
    assign bus.result_reg_addr_out = r_addr[STAGES-1];
    assign bus.result              = r_res[STAGES-1];
    assign bus.cr0_xer             = r_cr[STAGES-1];

endmodule
